// File: rtl/mcp_instr_sequencer_pkg.sv
// Shared types and default sizes for the multi-cycle-processor instruction sequencer.
package mcp_instr_sequencer_pkg;

    localparam int unsigned INSTR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned DEPTH_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W       = 16;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StErr
    } seq_state_e;

endpackage

// File: rtl/mcp_instr_sequencer_if.sv
// Start/done handshake between the sequencer (master) and the multi-cycle processor (slave).
interface mcp_instr_sequencer_if
    import mcp_instr_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
);

    logic [INSTR_W-1:0] cp_instr;
    logic               cp_start;
    logic               cp_done;
    logic [DATA_W-1:0]  cp_mem_out;
    logic [DATA_W-1:0]  cp_reg_out;

    modport master (
        output cp_instr,
        output cp_start,
        input  cp_done,
        input  cp_mem_out,
        input  cp_reg_out
    );

    modport slave (
        input  cp_instr,
        input  cp_start,
        output cp_done,
        output cp_mem_out,
        output cp_reg_out
    );

endinterface

// File: rtl/mcp_instr_sequencer_fifo.sv
// Synchronous program FIFO; full/empty decode from a registered occupancy count.
module mcp_instr_sequencer_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot early
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mcp_instr_sequencer.sv
// Buffers a program and issues it one instruction at a time over the start/done handshake,
// capturing mem_out/reg_out per completed instruction.
module mcp_instr_sequencer
    import mcp_instr_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid_i,
    input  logic [INSTR_W-1:0]   load_instr_i,
    output logic                 load_ready_o,
    input  logic                 run_i,
    mcp_instr_sequencer_if.master cp_if,
    output logic                 res_valid_o,
    output logic [DATA_W-1:0]    res_mem_o,
    output logic [DATA_W-1:0]    res_reg_o,
    output logic [CNT_W-1:0]     issued_cnt_o,
    output logic                 busy_o,
    output logic                 timeout_err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    seq_state_e         state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [TW-1:0]      timer_q;
    logic               res_valid_q;
    logic [DATA_W-1:0]  res_mem_q;
    logic [DATA_W-1:0]  res_reg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [INSTR_W-1:0] fifo_rdata;
    logic               can_issue;

    mcp_instr_sequencer_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (load_valid_i),
        .wdata_i (load_instr_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign can_issue = run_i && !fifo_empty;

    // Pop the head whenever the FSM is about to move into ISSUE
    always_comb begin
        fifo_pop = 1'b0;
        case (state_q)
            StIdle:  fifo_pop = can_issue;
            StWait:  fifo_pop = cp_if.cp_done && can_issue;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Sequencer FSM with its timer, result capture, completion counter and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            timer_q     <= '0;
            res_valid_q <= 1'b0;
            res_mem_q   <= '0;
            res_reg_q   <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (can_issue) begin
                        state_q <= StIssue;
                        instr_q <= fifo_rdata;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    timer_q <= '0;
                end
                StWait: begin
                    if (cp_if.cp_done) begin
                        res_valid_q <= 1'b1;
                        res_mem_q   <= cp_if.cp_mem_out;
                        res_reg_q   <= cp_if.cp_reg_out;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        if (can_issue) begin
                            state_q <= StIssue;
                            instr_q <= fifo_rdata;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        // TIMEOUT wait cycles have elapsed without done
                        state_q <= StErr;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StErr: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cp_if.cp_instr = instr_q;
    assign cp_if.cp_start = (state_q == StIssue);
    assign load_ready_o   = !fifo_full;
    assign res_valid_o    = res_valid_q;
    assign res_mem_o      = res_mem_q;
    assign res_reg_o      = res_reg_q;
    assign issued_cnt_o   = cnt_q;
    assign busy_o         = (state_q != StIdle);
    assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_mcp_instr_sequencer.sv
// Self-checking bench: a responder plays the multi-cycle processor, the model is a queue of
// loaded words (expected issue order) and a queue of returned results.
module tb_mcp_instr_sequencer;

    localparam int unsigned INSTR_W = 18;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 255;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_valid;
    logic [INSTR_W-1:0] load_instr;
    logic               load_ready;
    logic               run;
    logic               res_valid;
    logic [DATA_W-1:0]  res_mem;
    logic [DATA_W-1:0]  res_reg;
    logic [15:0]        issued_cnt;
    logic               busy;
    logic               timeout_err;

    mcp_instr_sequencer_if #(.INSTR_W(INSTR_W), .DATA_W(DATA_W)) cp_if ();

    mcp_instr_sequencer #(
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid_i  (load_valid),
        .load_instr_i  (load_instr),
        .load_ready_o  (load_ready),
        .run_i         (run),
        .cp_if         (cp_if),
        .res_valid_o   (res_valid),
        .res_mem_o     (res_mem),
        .res_reg_o     (res_reg),
        .issued_cnt_o  (issued_cnt),
        .busy_o        (busy),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [INSTR_W-1:0]  exp_prog[$];
    logic [2*DATA_W-1:0] exp_res[$];
    int                  model_cnt = 0;
    int                  start_cnt = 0;
    int                  res_cnt   = 0;
    int                  lat_mode  = 0;  // 0: random latency, >0: fixed, <0: never answer
    int                  idle_req  = 0;
    logic [DATA_W-1:0]   idle_mem  = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Processor stand-in plus issue/result monitor, all on the falling edge
    initial begin : responder
        int                  cd;
        int                  idle_ack;
        logic                prev_start;
        logic [2*DATA_W-1:0] e;
        logic [DATA_W-1:0]   m;
        logic [DATA_W-1:0]   r;
        cd = -1;
        idle_ack = 0;
        prev_start = 1'b0;
        cp_if.cp_done = 1'b0;
        cp_if.cp_mem_out = '0;
        cp_if.cp_reg_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cd = -1;
                prev_start = 1'b0;
                cp_if.cp_done = 1'b0;
                idle_ack = idle_req;
            end else begin
                if (res_valid) begin
                    res_cnt++;
                    if (exp_res.size() == 0) begin
                        check_eq("res_unexpected", 1, 0);
                    end else begin
                        e = exp_res.pop_front();
                        check_eq("res_mem", res_mem, e[2*DATA_W-1:DATA_W]);
                        check_eq("res_reg", res_reg, e[DATA_W-1:0]);
                    end
                    model_cnt = (model_cnt + 1) % 65536;
                    check_eq("issued_cnt", issued_cnt, model_cnt);
                end
                if (cp_if.cp_start) begin
                    start_cnt++;
                    check_eq("start_width", prev_start, 0);
                    if (exp_prog.size() == 0) check_eq("start_unexpected", 1, 0);
                    else check_eq("cp_instr", cp_if.cp_instr, exp_prog.pop_front());
                end
                cp_if.cp_done = 1'b0;
                if (cd == 0) begin
                    m = DATA_W'($urandom);
                    r = DATA_W'($urandom);
                    cp_if.cp_done = 1'b1;
                    cp_if.cp_mem_out = m;
                    cp_if.cp_reg_out = r;
                    exp_res.push_back({m, r});
                    cd = -1;
                end else if (cd > 0) begin
                    cd--;
                end
                if (cp_if.cp_start && lat_mode >= 0) begin
                    cd = ((lat_mode == 0) ? int'($urandom_range(6, 1)) : lat_mode) - 1;
                end else if (cd < 0 && !cp_if.cp_done && idle_req != idle_ack) begin
                    // Stray done while the sequencer is idle: must be ignored
                    idle_ack++;
                    cp_if.cp_done = 1'b1;
                    cp_if.cp_mem_out = idle_mem;
                    cp_if.cp_reg_out = DATA_W'($urandom);
                end
                prev_start = cp_if.cp_start;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_word(input logic [INSTR_W-1:0] w);
        int guard;
        guard = 0;
        load_valid = 1'b1;
        load_instr = w;
        while (!load_ready && guard < 1000) begin
            tick();
            guard++;
        end
        if (!load_ready) check_eq("load_ready_wait", load_ready, 1);
        else exp_prog.push_back(w);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(exp_prog.size() == 0 && exp_res.size() == 0 && !busy) && n < limit);
        check_eq(tag, 32'(exp_prog.size() == 0 && exp_res.size() == 0 && !busy), 1);
    endtask

    task automatic wait_start(input string tag);
        int s0;
        int n;
        s0 = start_cnt;
        n = 0;
        while (start_cnt == s0 && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(start_cnt != s0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        load_valid = 1'b0;
        exp_prog.delete();
        exp_res.delete();
        model_cnt = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s0;
        int r0;
        int n;
        load_valid = 1'b0;
        load_instr = '0;
        run = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_load_ready", load_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cp_start", cp_if.cp_start, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_issued_cnt", issued_cnt, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_cp_instr", cp_if.cp_instr, 0);
        rst = 1'b0;
        tick();

        // Three words, fixed 4-cycle done latency
        lat_mode = 4;
        load_word(18'h00001);
        load_word(18'h00002);
        load_word(18'h00003);
        s0 = start_cnt;
        run = 1'b1;
        wait_drain("t1_drain", 200);
        check_eq("t1_starts", start_cnt - s0, 3);
        check_eq("t1_cnt", issued_cnt, 3);
        check_eq("t1_busy", busy, 0);
        run = 1'b0;

        // Fill to capacity, reject one more, then drain
        lat_mode = 0;
        for (int i = 0; i < int'(DEPTH); i++) load_word(INSTR_W'($urandom));
        check_eq("t2_full_ready", load_ready, 0);
        load_valid = 1'b1;
        load_instr = INSTR_W'($urandom);
        tick();
        tick();
        load_valid = 1'b0;
        check_eq("t2_still_full", load_ready, 0);
        r0 = res_cnt;
        run = 1'b1;
        wait_start("t2_first_start");
        check_eq("t2_ready_after_pop", load_ready, 1);
        wait_drain("t2_drain", 600);
        check_eq("t2_results", res_cnt - r0, DEPTH);
        check_eq("t2_cnt", issued_cnt, 3 + DEPTH);
        run = 1'b0;

        // Done never returned
        lat_mode = -1;
        load_word(INSTR_W'($urandom));
        run = 1'b1;
        wait_start("t3_start");
        repeat (TIMEOUT - 15) tick();
        check_eq("t3_err_early", timeout_err, 0);
        repeat (30) tick();
        check_eq("t3_err", timeout_err, 1);
        check_eq("t3_busy", busy, 1);
        check_eq("t3_start_low", cp_if.cp_start, 0);
        load_word(INSTR_W'($urandom));
        s0 = start_cnt;
        repeat (20) tick();
        check_eq("t3_no_issue", start_cnt - s0, 0);
        check_eq("t3_err_sticky", timeout_err, 1);
        do_reset();
        check_eq("t3_err_clr", timeout_err, 0);
        check_eq("t3_busy_clr", busy, 0);
        check_eq("t3_cnt_clr", issued_cnt, 0);
        lat_mode = 0;

        // Drop run while the first of four words is outstanding
        lat_mode = 4;
        for (int i = 0; i < 4; i++) load_word(INSTR_W'($urandom));
        s0 = start_cnt;
        run = 1'b1;
        wait_start("t4_start");
        tick();
        run = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check_eq("t4_idle", busy, 0);
        check_eq("t4_one_done", issued_cnt, 1);
        repeat (5) tick();
        check_eq("t4_paused", start_cnt - s0, 1);
        run = 1'b1;
        wait_drain("t4_drain", 200);
        check_eq("t4_total", issued_cnt, 4);
        run = 1'b0;

        // Done pulsed while idle
        r0 = res_cnt;
        idle_mem = 8'hAA;
        idle_req++;
        repeat (6) tick();
        check_eq("t5_no_result", res_cnt - r0, 0);
        check_eq("t5_cnt", issued_cnt, 4);

        // Reset in the middle of a wait
        load_word(INSTR_W'($urandom));
        load_word(INSTR_W'($urandom));
        run = 1'b1;
        wait_start("t6_start");
        tick();
        check_eq("t6_busy_pre", busy, 1);
        r0 = res_cnt;
        s0 = start_cnt;
        rst = 1'b1;
        #1;
        check_eq("t6_start", cp_if.cp_start, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_load_ready", load_ready, 1);
        check_eq("t6_res_valid", res_valid, 0);
        exp_prog.delete();
        exp_res.delete();
        model_cnt = 0;
        tick();
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check_eq("t6_no_result", res_cnt - r0, 0);
        check_eq("t6_no_issue", start_cnt - s0, 0);
        check_eq("t6_ready", load_ready, 1);
        run = 1'b0;

        // Randomized rounds with run toggling during loads
        lat_mode = 0;
        for (int round = 0; round < 6; round++) begin
            int nw;
            nw = int'($urandom_range(10, 1));
            run = 1'($urandom_range(1, 0));
            for (int i = 0; i < nw; i++) begin
                load_word(INSTR_W'($urandom));
                if ($urandom_range(3, 0) == 0) run = ~run;
            end
            run = 1'b1;
            wait_drain("rnd_drain", 600);
        end
        run = 1'b0;
        tick();
        check_eq("end_busy", busy, 0);
        check_eq("end_cnt", issued_cnt, model_cnt);
        check_eq("end_err", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
